// File: rtl/boot_loader_pkg.sv
// Shared definitions for the UART boot loader: command/response codes and FSM states.
// No logic here; constants and types only.
// Imported by uart_boot_loader and boot_word_packer.
package boot_loader_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_HOLD    = 8'h02;
    localparam logic [7:0] CMD_RELEASE = 8'h03;

    localparam logic [7:0] RSP_ACK     = 8'h06;
    localparam logic [7:0] RSP_NAK     = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        TARGET,
        ADDR_LO,
        ADDR_HI,
        COUNT,
        DATA,
        CHECKSUM,
        RESPOND
    } state_t;

endpackage

// File: rtl/boot_word_packer.sv
// Packs incoming bytes little-endian into DATA_BYTES-wide words and emits one-hot write strobes.
// Latency: strobe, address and data are registered one cycle after the last byte of a word.
// No backpressure: every byte_valid is consumed; strobes are suppressed for out-of-range targets.
module boot_word_packer
    import boot_loader_pkg::*;
#(
    parameter int DATA_BYTES  = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int NUM_TARGETS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [ADDR_WIDTH-1:0]     load_addr,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    input  logic [7:0]                target,
    output logic                      word_end,
    output logic [ADDR_WIDTH-1:0]     mem_write_addr,
    output logic [8*DATA_BYTES-1:0]   mem_write_data,
    output logic [NUM_TARGETS-1:0]    mem_write_req
);

    localparam int IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int WORD_W = 8 * DATA_BYTES;

    logic [IDX_W-1:0]       idx;
    logic [WORD_W-1:0]      word_acc;
    logic [WORD_W-1:0]      word_next;
    logic [ADDR_WIDTH-1:0]  addr_ptr;
    logic [NUM_TARGETS-1:0] target_onehot;

    assign word_end = byte_valid && (idx == IDX_W'(DATA_BYTES - 1));

    // Merge the current byte into its little-endian lane of the partial word.
    always_comb begin
        word_next = word_acc;
        word_next[{idx, 3'b000} +: 8] = byte_data;
    end

    // Decode target to a strobe mask; a target past NUM_TARGETS matches no bit.
    always_comb begin
        target_onehot = '0;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            target_onehot[t] = (target == 8'(t));
        end
    end

    // Byte index, word accumulator, address pointer and registered write outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx            <= '0;
            word_acc       <= '0;
            addr_ptr       <= '0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            mem_write_req  <= '0;
        end else begin
            mem_write_req <= '0;
            if (load) begin
                idx      <= '0;
                word_acc <= '0;
                addr_ptr <= load_addr;
            end else if (byte_valid) begin
                if (word_end) begin
                    idx            <= '0;
                    word_acc       <= '0;
                    mem_write_data <= word_next;
                    mem_write_addr <= addr_ptr;
                    addr_ptr       <= addr_ptr + 1'b1;
                    mem_write_req  <= target_onehot;
                end else begin
                    idx      <= idx + 1'b1;
                    word_acc <= word_next;
                end
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Parses framed UART commands, streams WRITE payloads into target memories, answers ACK/NAK.
// Latency: memory strobe one cycle after a word's last byte; response one cycle after the frame's last byte.
// tx_valid holds with stable tx_data until tx_ready; rx bytes arriving while a response is pending are dropped.
module uart_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DATA_BYTES     = 4,
    parameter int ADDR_WIDTH     = 12,
    parameter int NUM_TARGETS    = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit RESET_HOLD     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      system_soft_reset,
    output logic [ADDR_WIDTH-1:0]     mem_write_addr,
    output logic [8*DATA_BYTES-1:0]   mem_write_data,
    output logic [NUM_TARGETS-1:0]    mem_write_req,
    output logic                      busy,
    output logic [7:0]                error_count
);

    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t              state, state_next;
    logic [7:0]          target_q;
    logic [7:0]          addr_lo_q;
    logic [8:0]          words_left;
    logic [7:0]          sum_q;
    logic [7:0]          sum_add;
    logic [TCNT_W-1:0]   tcnt;
    logic                active;
    logic                timeout_hit;
    logic                target_ok;
    logic                word_end;

    logic                pk_load;
    logic                pk_byte_valid;
    logic                tx_load;
    logic [7:0]          tx_byte;
    logic                soft_set;
    logic                soft_clr;
    logic                err_inc;

    assign sum_add     = sum_q + rx_data;
    assign target_ok   = target_q < 8'(NUM_TARGETS);
    assign active      = (state != IDLE) && (state != RESPOND);
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign timeout_hit = active && !rx_valid && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
    assign tx_valid    = (state == RESPOND);
    assign busy        = (state != IDLE);

    boot_word_packer #(
        .DATA_BYTES  (DATA_BYTES),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_TARGETS (NUM_TARGETS)
    ) u_packer (
        .clk            (clk),
        .reset          (reset),
        .load           (pk_load),
        .load_addr      (ADDR_WIDTH'({rx_data, addr_lo_q})),
        .byte_valid     (pk_byte_valid),
        .byte_data      (rx_data),
        .target         (target_q),
        .word_end       (word_end),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_req  (mem_write_req)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus per-cycle control strobes for the datapath.
    always_comb begin
        state_next    = state;
        pk_load       = 1'b0;
        pk_byte_valid = 1'b0;
        tx_load       = 1'b0;
        tx_byte       = RSP_ACK;
        soft_set      = 1'b0;
        soft_clr      = 1'b0;
        err_inc       = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_WRITE: begin
                            state_next = TARGET;
                            soft_set   = 1'b1;
                        end
                        CMD_HOLD: begin
                            state_next = RESPOND;
                            tx_load    = 1'b1;
                            soft_set   = 1'b1;
                        end
                        CMD_RELEASE: begin
                            state_next = RESPOND;
                            tx_load    = 1'b1;
                            soft_clr   = 1'b1;
                        end
                        default: begin
                            state_next = RESPOND;
                            tx_load    = 1'b1;
                            tx_byte    = RSP_NAK;
                            err_inc    = 1'b1;
                        end
                    endcase
                end
            end
            TARGET:  if (rx_valid) state_next = ADDR_LO;
            ADDR_LO: if (rx_valid) state_next = ADDR_HI;
            ADDR_HI: begin
                if (rx_valid) begin
                    pk_load    = 1'b1;
                    state_next = COUNT;
                end
            end
            COUNT:   if (rx_valid) state_next = DATA;
            DATA: begin
                pk_byte_valid = rx_valid;
                if (rx_valid && word_end && (words_left == 9'd1)) begin
                    state_next = CHECKSUM;
                end
            end
            CHECKSUM: begin
                if (rx_valid) begin
                    state_next = RESPOND;
                    tx_load    = 1'b1;
                    if ((sum_add != 8'h00) || !target_ok) begin
                        tx_byte = RSP_NAK;
                        err_inc = 1'b1;
                    end
                end
            end
            RESPOND: if (tx_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = IDLE;
            err_inc    = 1'b1;
        end
    end

    // Frame fields, running checksum, inter-byte timer, response byte, soft reset and error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q          <= '0;
            addr_lo_q         <= '0;
            words_left        <= '0;
            sum_q             <= '0;
            tcnt              <= '0;
            tx_data           <= '0;
            system_soft_reset <= RESET_HOLD;
            error_count       <= '0;
        end else begin
            if (rx_valid) begin
                case (state)
                    IDLE:    sum_q <= '0;
                    TARGET: begin
                        target_q <= rx_data;
                        sum_q    <= sum_add;
                    end
                    ADDR_LO: begin
                        addr_lo_q <= rx_data;
                        sum_q     <= sum_add;
                    end
                    ADDR_HI: sum_q <= sum_add;
                    COUNT: begin
                        words_left <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        sum_q      <= sum_add;
                    end
                    DATA: begin
                        sum_q <= sum_add;
                        if (word_end) words_left <= words_left - 9'd1;
                    end
                    default: ;
                endcase
            end
            if (rx_valid || !active || timeout_hit) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
            if (tx_load) tx_data <= tx_byte;
            if (soft_set) begin
                system_soft_reset <= 1'b1;
            end else if (soft_clr) begin
                system_soft_reset <= 1'b0;
            end
            if (err_inc && (error_count != 8'hFF)) begin
                error_count <= error_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: command frames, checksum, target range, wrap, timeout, backpressure, reset.
module tb_uart_boot_loader;

    localparam int DB = 4;
    localparam int AW = 12;
    localparam int NT = 2;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          system_soft_reset;
    logic [AW-1:0] mem_write_addr;
    logic [8*DB-1:0] mem_write_data;
    logic [NT-1:0] mem_write_req;
    logic          busy;
    logic [7:0]    error_count;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;

    logic [AW-1:0]   wr_addr_q[$];
    logic [8*DB-1:0] wr_data_q[$];
    logic [NT-1:0]   wr_req_q[$];
    logic [7:0]      tx_q[$];
    logic [7:0]      frame[$];

    uart_boot_loader #(
        .DATA_BYTES     (DB),
        .ADDR_WIDTH     (AW),
        .NUM_TARGETS    (NT),
        .TIMEOUT_CYCLES (TO),
        .RESET_HOLD     (1'b1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .system_soft_reset (system_soft_reset),
        .mem_write_addr    (mem_write_addr),
        .mem_write_data    (mem_write_data),
        .mem_write_req     (mem_write_req),
        .busy              (busy),
        .error_count       (error_count)
    );

    always #5 clk = ~clk;

    // Record every strobe cycle and every accepted response byte.
    always @(negedge clk) begin
        if (mem_write_req !== '0) begin
            wr_addr_q.push_back(mem_write_addr);
            wr_data_q.push_back(mem_write_data);
            wr_req_q.push_back(mem_write_req);
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
    endtask

    function automatic logic [7:0] frame_cks();
        logic [7:0] s;
        s = 8'h00;
        for (int i = 1; i < frame.size(); i++) s = s + frame[i];
        return 8'h00 - s;
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_req_q.delete(); tx_q.delete();
    endtask

    task automatic wait_rsp(input string name, input logic [7:0] exp);
        int n;
        n = 0;
        while (tx_q.size() == 0 && n < 100) begin
            @(posedge clk); n++;
        end
        @(posedge clk); #1;
        checks++;
        if (tx_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no response byte within 100 cycles, required %h", name, exp);
        end else if (tx_q[0] !== exp) begin
            errors++;
            $display("FAIL %s: response %h, required %h", name, tx_q[0], exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
        checks++; if (mem_write_req !== 2'b00) begin errors++; $display("FAIL reset_req: got %b required 00", mem_write_req); end
        checks++; if (mem_write_addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h required 000", mem_write_addr); end
        checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", mem_write_data); end
        checks++; if (system_soft_reset !== 1'b1) begin errors++; $display("FAIL reset_soft: got %b required 1", system_soft_reset); end
        checks++; if (error_count !== 8'h00) begin errors++; $display("FAIL reset_errcnt: got %0d required 0", error_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_hold_release();
        clear_logs();
        send_byte(8'h03);
        checks++; if (system_soft_reset !== 1'b0) begin errors++; $display("FAIL release_soft: got %b required 0", system_soft_reset); end
        wait_rsp("release_ack", 8'h06);
        clear_logs();
        send_byte(8'h02);
        checks++; if (system_soft_reset !== 1'b1) begin errors++; $display("FAIL hold_soft: got %b required 1", system_soft_reset); end
        wait_rsp("hold_ack", 8'h06);
        clear_logs();
        send_byte(8'h03);
        wait_rsp("release2_ack", 8'h06);
        clear_logs();
        send_byte(8'h7E);
        exp_err++;
        wait_rsp("unknown_nak", 8'h15);
        checks++; if (error_count !== 8'(exp_err)) begin errors++; $display("FAIL unknown_errcnt: got %0d required %0d", error_count, exp_err); end
        checks++; if (system_soft_reset !== 1'b0) begin errors++; $display("FAIL unknown_soft: got %b required 0", system_soft_reset); end
    endtask

    task automatic run_two_word_write(input logic [7:0] cks, input string name, input logic [7:0] rsp);
        clear_logs();
        send_byte(8'h01);
        checks++; if (system_soft_reset !== 1'b1) begin errors++; $display("FAIL %s_soft_forced: got %b required 1", name, system_soft_reset); end
        frame = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, cks};
        send_frame();
        wait_rsp(name, rsp);
        checks++;
        if (wr_req_q.size() != 2) begin
            errors++; $display("FAIL %s_nwrites: got %0d required 2", name, wr_req_q.size());
        end else if (wr_addr_q[0] !== 12'h010 || wr_data_q[0] !== 32'h44332211 || wr_req_q[0] !== 2'b01 ||
                     wr_addr_q[1] !== 12'h011 || wr_data_q[1] !== 32'h88776655 || wr_req_q[1] !== 2'b01) begin
            errors++;
            $display("FAIL %s_writes: got %h/%h/%b %h/%h/%b required 010/44332211/01 011/88776655/01", name,
                     wr_addr_q[0], wr_data_q[0], wr_req_q[0], wr_addr_q[1], wr_data_q[1], wr_req_q[1]);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b required 0", name, busy); end
        checks++; if (error_count !== 8'(exp_err)) begin errors++; $display("FAIL %s_errcnt: got %0d required %0d", name, error_count, exp_err); end
    endtask

    task automatic test_write_ack();
        run_two_word_write(8'h8A, "write_ack", 8'h06);
        checks++; if (system_soft_reset !== 1'b1) begin errors++; $display("FAIL write_soft_after: got %b required 1", system_soft_reset); end
    endtask

    task automatic test_bad_checksum();
        send_byte(8'h03);
        wait_rsp("pre_bad_release", 8'h06);
        exp_err++;
        run_two_word_write(8'h8B, "bad_cks", 8'h15);
    endtask

    task automatic test_bad_target();
        clear_logs();
        frame = '{8'h01, 8'h05, 8'h20, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        frame.push_back(frame_cks());
        send_frame();
        exp_err++;
        wait_rsp("bad_target", 8'h15);
        checks++; if (wr_req_q.size() != 0) begin errors++; $display("FAIL bad_target_strobes: got %0d writes required 0", wr_req_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_target_idle: busy %b required 0", busy); end
        checks++; if (error_count !== 8'(exp_err)) begin errors++; $display("FAIL bad_target_errcnt: got %0d required %0d", error_count, exp_err); end
    endtask

    task automatic test_wrap();
        clear_logs();
        frame = '{8'h01, 8'h01, 8'hFF, 8'h0F, 8'h02, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
                  8'hA4, 8'hA5, 8'hA6, 8'hA7};
        frame.push_back(frame_cks());
        send_frame();
        wait_rsp("wrap_ack", 8'h06);
        checks++;
        if (wr_req_q.size() != 2) begin
            errors++; $display("FAIL wrap_nwrites: got %0d required 2", wr_req_q.size());
        end else if (wr_addr_q[0] !== 12'hFFF || wr_data_q[0] !== 32'hA3A2A1A0 || wr_req_q[0] !== 2'b10 ||
                     wr_addr_q[1] !== 12'h000 || wr_data_q[1] !== 32'hA7A6A5A4 || wr_req_q[1] !== 2'b10) begin
            errors++;
            $display("FAIL wrap_writes: got %h/%h/%b %h/%h/%b required FFF/A3A2A1A0/10 000/A7A6A5A4/10",
                     wr_addr_q[0], wr_data_q[0], wr_req_q[0], wr_addr_q[1], wr_data_q[1], wr_req_q[1]);
        end
    endtask

    task automatic test_count_zero();
        int bad;
        clear_logs();
        frame = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
        for (int w = 0; w < 256; w++) begin
            frame.push_back(8'(w)); frame.push_back(8'h5A);
            frame.push_back(~8'(w)); frame.push_back(8'hC3);
        end
        frame.push_back(frame_cks());
        send_frame();
        wait_rsp("count0_ack", 8'h06);
        checks++;
        if (wr_req_q.size() != 256) begin
            errors++; $display("FAIL count0_nwrites: got %0d required 256", wr_req_q.size());
        end
        bad = 0;
        for (int w = 0; w < wr_req_q.size() && w < 256; w++) begin
            if (wr_addr_q[w] !== 12'(12'h100 + w) || wr_data_q[w] !== {8'hC3, ~8'(w), 8'h5A, 8'(w)} || wr_req_q[w] !== 2'b01)
                bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL count0_words: %0d bad words, required 0", bad); end
    endtask

    task automatic test_timeout();
        int n;
        clear_logs();
        frame = '{8'h01, 8'h00, 8'h34, 8'h12};
        send_frame();
        repeat (TO - 5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_early: busy %b required 1 before expiry", busy); end
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            @(posedge clk); #1; n++;
        end
        exp_err++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy %b required 0 within 30 cycles", busy); end
        checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL timeout_no_rsp: got %0d bytes required 0", tx_q.size()); end
        checks++; if (error_count !== 8'(exp_err)) begin errors++; $display("FAIL timeout_errcnt: got %0d required %0d", error_count, exp_err); end
        clear_logs();
        send_byte(8'h03);
        wait_rsp("timeout_release", 8'h06);
        checks++; if (system_soft_reset !== 1'b0) begin errors++; $display("FAIL timeout_release_soft: got %b required 0", system_soft_reset); end
    endtask

    task automatic test_backpressure();
        int unstable;
        clear_logs();
        tx_ready = 1'b0;
        send_byte(8'h02);
        @(posedge clk); #1;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin errors++; $display("FAIL bp_pending: valid %b data %h required 1 06", tx_valid, tx_data); end
        unstable = 0;
        for (int i = 0; i < 25; i++) begin
            send_byte((i % 2 == 0) ? 8'h7E : 8'h01);
            if (tx_valid !== 1'b1 || tx_data !== 8'h06) unstable++;
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: %0d unstable samples required 0", unstable); end
        checks++; if (error_count !== 8'(exp_err) || wr_req_q.size() != 0) begin
            errors++; $display("FAIL bp_dropped: errcnt %0d writes %0d required %0d 0", error_count, wr_req_q.size(), exp_err);
        end
        tx_ready = 1'b1;
        wait_rsp("bp_ack", 8'h06);
        checks++; if (tx_q.size() != 1 || busy !== 1'b0) begin errors++; $display("FAIL bp_single: %0d bytes busy %b required 1 0", tx_q.size(), busy); end
    endtask

    task automatic test_reset_mid_data();
        send_byte(8'h03);
        wait_rsp("pre_rst_release", 8'h06);
        clear_logs();
        frame = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame();
        checks++; if (wr_req_q.size() != 1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre: writes %0d busy %b required 1 1", wr_req_q.size(), busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL rst_ctrl: busy %b tx_valid %b tx_data %h required 0 0 00", busy, tx_valid, tx_data);
        end
        checks++; if (mem_write_req !== 2'b00 || mem_write_addr !== 12'h000 || mem_write_data !== 32'h0) begin
            errors++; $display("FAIL rst_mem: req %b addr %h data %h required 00 000 0", mem_write_req, mem_write_addr, mem_write_data);
        end
        checks++; if (system_soft_reset !== 1'b1 || error_count !== 8'h00) begin
            errors++; $display("FAIL rst_soft_err: soft %b errcnt %0d required 1 0", system_soft_reset, error_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        send_byte(8'h03);
        wait_rsp("post_rst_release", 8'h06);
    endtask

    initial begin
        test_reset();
        test_hold_release();
        test_write_ack();
        test_bad_checksum();
        test_bad_target();
        test_wrap();
        test_count_zero();
        test_timeout();
        test_backpressure();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Parametrised successor to the single-target UART ROM loader.
- Consumes the byte stream from uart_receiver and parses framed commands.
- Assembles little-endian words of configurable width and writes them to one of NUM_TARGETS memories (program ROM, data RAM, ...) through one-hot write strobes.
- Adds per-frame checksum, ACK/NAK response bytes for a UART transmitter, an inter-byte timeout, and explicit hold/release control of the system soft reset.

Parameters:
- DATA_BYTES, 4, bytes per memory word; mem_write_data width = 8*DATA_BYTES (1..8)
- ADDR_WIDTH, 12, word-address width (1..16)
- NUM_TARGETS, 2, number of writable memories (1..8)
- TIMEOUT_CYCLES, 1000000, idle clk cycles between bytes before a partial frame is abandoned
- RESET_HOLD, 1, value of system_soft_reset out of reset

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid
- tx_data  out  8  response byte
- tx_valid  out  1  response pending; held until tx_ready
- tx_ready  in  1  transmitter accepts tx_data this cycle
- system_soft_reset  out  1  holds the rest of the system in reset
- mem_write_addr  out  ADDR_WIDTH  word address
- mem_write_data  out  8*DATA_BYTES  word data
- mem_write_req  out  NUM_TARGETS  one-hot, one-cycle write strobe
- busy  out  1  high in any state other than IDLE
- error_count  out  8  saturating count of NAKs and timeouts

Behaviour:
- Reset values:
  - FSM = IDLE.
  - tx_valid = 0, tx_data = 0.
  - mem_write_req = 0, mem_write_addr = 0, mem_write_data = 0.
  - system_soft_reset = RESET_HOLD.
  - error_count = 0.
  - A reset mid-frame discards the frame with no response.
- Commands (first byte of a frame):
  - 0x01 WRITE: target, addr_lo, addr_hi, count, then count*DATA_BYTES data bytes, then checksum.
  - 0x02 HOLD: set system_soft_reset = 1 on the following cycle, respond ACK.
  - 0x03 RELEASE: clear system_soft_reset on the following cycle, respond ACK.
  - Any other byte: respond NAK.
- WRITE frame rules:
  - count = 0 means 256 words.
  - Address = {addr_hi, addr_lo} truncated to ADDR_WIDTH.
  - system_soft_reset is forced to 1 on the cycle after the 0x01 byte and stays asserted after the frame.
- FSM states: IDLE, TARGET, ADDR_LO, ADDR_HI, COUNT, DATA, CHECKSUM, RESPOND. Each rx_valid advances exactly one field.
- Word assembly:
  - Byte k of a word goes to bits [8k+7:8k].
  - On the cycle after the last byte of a word: mem_write_req[target] = 1 for exactly one cycle, with mem_write_addr and mem_write_data valid.
  - Address increments after each write and wraps modulo 2^ADDR_WIDTH.
  - Writes stream as words arrive; a bad checksum does not roll back earlier writes.
- Target validation:
  - If target >= NUM_TARGETS, the frame is still consumed in full, but all strobes are suppressed and the response is NAK.
- Checksum and response:
  - The 8-bit sum of every byte after the command byte, including the checksum byte, must equal 0x00.
  - Pass gives ACK 0x06; fail gives NAK 0x15.
- RESPOND:
  - tx_valid = 1 with tx_data stable until tx_ready; then return to IDLE on the next cycle.
  - rx bytes arriving in RESPOND are dropped.
- Timeout:
  - Counter clears on every rx_valid and counts only when FSM is not IDLE or RESPOND.
  - On reaching TIMEOUT_CYCLES: return to IDLE, send no response, increment error_count.
  - If rx_valid and timeout occur in the same cycle, the byte wins and the counter clears.
- error_count increments on each NAK and each timeout, saturating at 255.

Decomposition:
- boot_loader_pkg holds:
  - command codes CMD_WRITE, CMD_HOLD, CMD_RELEASE
  - response codes RSP_ACK, RSP_NAK
  - the state_t enum
- Sub-module boot_word_packer handles DATA_BYTES-wide shift-in, the byte index counter, the word-complete pulse, and the address incrementer with wrap.
- The top-level FSM, checksum, timeout and tx holding register stay in uart_boot_loader.

Test Plan:
- WRITE to target 0, addr 0x0010, count 2, data 11 22 33 44 55 66 77 88, correct checksum -> one strobe to addr 0x010 with 0x44332211, one to addr 0x011 with 0x88776655, tx byte 0x06, system_soft_reset = 1.
- Same frame with checksum off by one -> both writes still occur, tx byte 0x15, error_count = 1.
- WRITE with target 5 (NUM_TARGETS = 2) -> no mem_write_req bit ever set, NAK, FSM back in IDLE.
- WRITE at addr 0x0FFF, count 2 -> writes to 0xFFF then 0x000 (wrap).
- Frame stopped after the addr_hi byte, then 1,000,000 idle cycles -> busy falls, no tx_valid, error_count increments; next 0x03 -> ACK and system_soft_reset = 0.
- tx_ready held low for 50 cycles during RESPOND while bytes arrive -> tx_data stable, bytes ignored; reset asserted mid-DATA -> all outputs return to reset values.
